// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit for the pipelined MIPS core.
//
// Takes one instruction from the EX/MEM register and produces one result for
// the MEM/WB register. Pass-through ops, misaligned accesses and failed SCs
// complete with no bus activity. Every other memory op becomes a single bus
// transaction, and the pipeline is held while that transaction runs.
// Byte lanes are big-endian: lane offset 0 is bits DATA_W-1..DATA_W-8, and
// bus_sel[SEL_W-1] enables the lowest address.
//
// Handshakes:
//   Pipeline side: in_valid is sampled only in IDLE. stall_o tells the
//   pipeline to hold its inputs steady while a bus cycle is in flight.
//   out_valid is a one-cycle pulse that carries wd_o/wreg_o/wdata_o/exc_*.
//   Bus side: bus_req stays high, and bus_addr/bus_we/bus_sel/bus_wdata stay
//   stable, until the cycle in which bus_ack is high. bus_rdata is valid in
//   that same cycle. An ack that arrives in any state other than BUS is
//   ignored.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid, op, addr         request from EX/MEM
//   st_data, wd_i, wreg_i      store operand / pass value, destination
//   llbit_clr                  exception/ERET clear of the LL link bit
//   stall_o                    stall request to pipeline control
//   out_valid, wd_o, wreg_o    result to MEM/WB
//   wdata_o                    load / SC / pass-through result
//   exc_adel, exc_ades         load / store address error pulses
//   badvaddr_o                 faulting address
//   bus_req, bus_we, bus_addr  data-bus master request
//   bus_sel, bus_wdata         byte enables, replicated store data
//   bus_ack, bus_rdata         completion and read data
module mem_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic              llbit_clr,
  output logic              stall_o,
  output logic              out_valid,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int OFF_W = $clog2(SEL_W);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_LWU = 4'd6;
  localparam logic [3:0] OP_LD  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SD  = 4'd11;
  localparam logic [3:0] OP_LL  = 4'd12;
  localparam logic [3:0] OP_SC  = 4'd13;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_t;

  state_t state_q, state_d;

  logic             link_q;
  logic [3:0]       size_q;
  logic             sgn_q, store_q, ll_q, sc_q, wreg_q;
  logic [OFF_W-1:0] off_q;
  logic [4:0]       wd_q;

  // ---------------- request decode ----------------
  logic [3:0]       op_eff;
  logic             dec_load, dec_store, dec_signed, dec_ll, dec_sc, dec_mem;
  logic [3:0]       dec_size;
  logic             misalign, link_eff, launch;
  logic [OFF_W-1:0] off;
  logic [SEL_W-1:0] sel_c;
  logic [DATA_W-1:0] wdata_c;

  always_comb begin
    op_eff = op;
    // Doubleword ops have no meaning on a 32-bit datapath; codes 14/15 are unused.
    if (op >= 4'd14) op_eff = OP_NOP;
    if (DATA_W != 64 && (op == OP_LWU || op == OP_LD || op == OP_SD)) op_eff = OP_NOP;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_signed = 1'b0;
    dec_ll     = 1'b0;
    dec_sc     = 1'b0;
    dec_size   = 4'd1;
    case (op_eff)
      OP_LB:  begin dec_load = 1'b1; dec_signed = 1'b1; end
      OP_LBU: dec_load = 1'b1;
      OP_LH:  begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 4'd2; end
      OP_LHU: begin dec_load = 1'b1; dec_size = 4'd2; end
      OP_LW:  begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = 4'd4; end
      OP_LWU: begin dec_load = 1'b1; dec_size = 4'd4; end
      OP_LD:  begin dec_load = 1'b1; dec_size = 4'd8; end
      OP_SB:  dec_store = 1'b1;
      OP_SH:  begin dec_store = 1'b1; dec_size = 4'd2; end
      OP_SW:  begin dec_store = 1'b1; dec_size = 4'd4; end
      OP_SD:  begin dec_store = 1'b1; dec_size = 4'd8; end
      OP_LL:  begin dec_load = 1'b1; dec_signed = 1'b1; dec_ll = 1'b1; dec_size = 4'd4; end
      OP_SC:  begin dec_store = 1'b1; dec_sc = 1'b1; dec_size = 4'd4; end
      default: ;
    endcase
  end

  assign dec_mem = dec_load | dec_store;
  assign off     = addr[OFF_W-1:0];

  always_comb begin
    case (dec_size)
      4'd2:    misalign = addr[0];
      4'd4:    misalign = (addr[1:0] != 2'b00);
      4'd8:    misalign = (addr[2:0] != 3'b000);
      default: misalign = 1'b0;
    endcase
  end

  // The SC decision sees a same-cycle llbit_clr as already applied.
  assign link_eff = link_q & ~llbit_clr;
  assign launch   = (state_q == S_IDLE) && in_valid && dec_mem && !misalign &&
                    !(dec_sc && !link_eff);

  // Byte offset i (counting from the lowest address) maps to sel bit SEL_W-1-i.
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < SEL_W; i++) begin
      if (i >= int'(off) && i < int'(off) + int'(dec_size))
        sel_c[SEL_W-1-i] = 1'b1;
    end
  end

  // The low dec_size bytes of the operand are repeated across every lane, so
  // any aligned position picks up the correct bytes.
  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < SEL_W; i++)
      wdata_c[i*8 +: 8] = st_data[(i % int'(dec_size))*8 +: 8];
  end

  // ---------------- load extract ----------------
  // Shift the addressed byte up to the MSB, then shift the field back down.
  // The downward shift is arithmetic for signed ops and logical otherwise.
  logic [DATA_W-1:0] rd_shift, ld_val;
  int                ld_sh;

  always_comb begin
    rd_shift = bus_rdata << {off_q, 3'b000};
    ld_sh    = DATA_W - 8 * int'(size_q);
    if (sgn_q) ld_val = $signed(rd_shift) >>> ld_sh;
    else       ld_val = rd_shift >> ld_sh;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: if (launch) begin
        state_d = S_BUS;
        stall_o = 1'b1;
      end
      S_BUS: begin
        stall_o = 1'b1;
        if (bus_ack) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      link_q     <= 1'b0;
      size_q     <= 4'd0;
      sgn_q      <= 1'b0;
      store_q    <= 1'b0;
      ll_q       <= 1'b0;
      sc_q       <= 1'b0;
      wreg_q     <= 1'b0;
      off_q      <= '0;
      wd_q       <= 5'd0;
      out_valid  <= 1'b0;
      wd_o       <= 5'd0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
      exc_adel   <= 1'b0;
      exc_ades   <= 1'b0;
      badvaddr_o <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_sel    <= '0;
      bus_wdata  <= '0;
    end else begin
      out_valid <= 1'b0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;

      // A clear beats a simultaneous LL completion.
      if (llbit_clr)                             link_q <= 1'b0;
      else if (state_q == S_BUS && bus_ack && ll_q) link_q <= 1'b1;
      else if (state_q == S_BUS && bus_ack && sc_q) link_q <= 1'b0;

      case (state_q)
        S_IDLE: if (in_valid) begin
          if (!dec_mem) begin
            out_valid <= 1'b1;
            wd_o      <= wd_i;
            wreg_o    <= wreg_i;
            wdata_o   <= st_data;
          end else if (misalign) begin
            out_valid  <= 1'b1;
            wd_o       <= wd_i;
            wreg_o     <= 1'b0;
            exc_adel   <= dec_load;
            exc_ades   <= dec_store;
            badvaddr_o <= addr;
          end else if (dec_sc && !link_eff) begin
            out_valid <= 1'b1;
            wd_o      <= wd_i;
            wreg_o    <= wreg_i;
            wdata_o   <= '0;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= dec_store;
            bus_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_sel   <= sel_c;
            bus_wdata <= wdata_c;
            size_q    <= dec_size;
            sgn_q     <= dec_signed;
            store_q   <= dec_store;
            ll_q      <= dec_ll;
            sc_q      <= dec_sc;
            off_q     <= off;
            wd_q      <= wd_i;
            wreg_q    <= wreg_i;
          end
        end
        S_BUS: if (bus_ack) begin
          bus_req   <= 1'b0;
          out_valid <= 1'b1;
          wd_o      <= wd_q;
          // Plain stores never write a register; SC writes its status.
          wreg_o    <= (!store_q || sc_q) ? wreg_q : 1'b0;
          if (sc_q)         wdata_o <= DATA_W'(1);
          else if (store_q) wdata_o <= '0;
          else              wdata_o <= ld_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu. The main instance is 32-bit and a second instance is
// 64-bit. Expected results come from a byte-addressed big-endian reference
// memory plus a link-bit model. A separate slave memory is updated only from
// what the DUT drives onto the bus, so wrong lane selects show up later as
// wrong load data.
module tb_mem_lsu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance
  logic        in_valid, wreg_i, llbit_clr, bus_ack;
  logic [3:0]  op;
  logic [31:0] addr, st_data, bus_rdata;
  logic [4:0]  wd_i;
  logic        stall_o, out_valid, wreg_o, exc_adel, exc_ades, bus_req, bus_we;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o, badvaddr_o, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;

  mem_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .addr(addr),
    .st_data(st_data), .wd_i(wd_i), .wreg_i(wreg_i), .llbit_clr(llbit_clr),
    .stall_o(stall_o), .out_valid(out_valid), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .badvaddr_o(badvaddr_o), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // 64-bit instance
  logic        d_in_valid, d_wreg_i, d_llbit_clr, d_bus_ack;
  logic [3:0]  d_op;
  logic [31:0] d_addr;
  logic [63:0] d_st_data, d_bus_rdata;
  logic [4:0]  d_wd_i;
  logic        d_stall_o, d_out_valid, d_wreg_o, d_exc_adel, d_exc_ades, d_bus_req, d_bus_we;
  logic [4:0]  d_wd_o;
  logic [63:0] d_wdata_o, d_bus_wdata;
  logic [31:0] d_badvaddr_o, d_bus_addr;
  logic [7:0]  d_bus_sel;

  mem_lsu #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .op(d_op), .addr(d_addr),
    .st_data(d_st_data), .wd_i(d_wd_i), .wreg_i(d_wreg_i), .llbit_clr(d_llbit_clr),
    .stall_o(d_stall_o), .out_valid(d_out_valid), .wd_o(d_wd_o), .wreg_o(d_wreg_o),
    .wdata_o(d_wdata_o), .exc_adel(d_exc_adel), .exc_ades(d_exc_ades),
    .badvaddr_o(d_badvaddr_o), .bus_req(d_bus_req), .bus_we(d_bus_we),
    .bus_addr(d_bus_addr), .bus_sel(d_bus_sel), .bus_wdata(d_bus_wdata),
    .bus_ack(d_bus_ack), .bus_rdata(d_bus_rdata)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ref_mem [int unsigned];
  logic [7:0] bus_mem [int unsigned];
  bit m_link = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int unsigned a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] bus_rd(input int unsigned a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_byte(a);
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      ref_mem[a + j] = w[(3-j)*8 +: 8];
      bus_mem[a + j] = w[(3-j)*8 +: 8];
    end
  endtask

  // ---------------- driver: one instruction on the 32-bit instance ----------------
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wd, input logic wr, input int dly, input bit clr_ack,
                       output logic [31:0] obs_w, output logic [3:0] obs_sel,
                       output logic [31:0] obs_bwd);
    int sz;
    bit ld, st, sgn, ll, sc, pass, mis, scfail, use_bus;
    logic [31:0] exp_v, exp_bwd, al;
    logic [3:0]  exp_sel;
    sz = 1; ld = 0; st = 0; sgn = 0; ll = 0; sc = 0;
    case (o)
      4'd1:  begin ld = 1; sgn = 1; end
      4'd2:  ld = 1;
      4'd3:  begin ld = 1; sgn = 1; sz = 2; end
      4'd4:  begin ld = 1; sz = 2; end
      4'd5:  begin ld = 1; sgn = 1; sz = 4; end
      4'd8:  st = 1;
      4'd9:  begin st = 1; sz = 2; end
      4'd10: begin st = 1; sz = 4; end
      4'd12: begin ld = 1; sgn = 1; ll = 1; sz = 4; end
      4'd13: begin st = 1; sc = 1; sz = 4; end
      default: ;
    endcase
    pass    = !(ld || st);
    mis     = !pass && (int'(a[2:0]) % sz != 0);
    scfail  = !pass && !mis && sc && !m_link;
    use_bus = !pass && !mis && !scfail;
    al      = a & ~32'd3;
    exp_sel = '0;
    for (int k = 0; k < 4; k++)
      if (k >= int'(a[1:0]) && k < int'(a[1:0]) + sz) exp_sel[3-k] = 1'b1;
    exp_bwd = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
    exp_v = '0;
    for (int j = 0; j < sz; j++) exp_v = (exp_v << 8) | 32'(ref_rd(a + j));
    if (sgn && sz < 4 && exp_v[sz*8-1]) exp_v = exp_v | ~((32'd1 << (sz*8)) - 32'd1);
    obs_w = '0; obs_sel = '0; obs_bwd = '0;

    @(negedge clk);
    in_valid = 1'b1; op = o; addr = a; st_data = sd; wd_i = wd; wreg_i = wr;
    #1 chk("stall_at_accept", stall_o, use_bus);
    @(posedge clk);
    if (!use_bus) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("out_valid_fast", out_valid, 1);
      chk("no_bus_req", bus_req, 0);
      chk("stall_fast", stall_o, 0);
      obs_w = wdata_o;
      if (mis) begin
        chk("mis_wreg", wreg_o, 0);
        chk("exc_adel", exc_adel, ld);
        chk("exc_ades", exc_ades, st);
        chk("badvaddr", badvaddr_o, a);
      end else begin
        chk("fast_wd", wd_o, wd);
        chk("fast_wreg", wreg_o, wr);
        chk("fast_wdata", wdata_o, pass ? sd : 32'd0);
        chk("fast_no_exc", {exc_adel, exc_ades}, 0);
      end
    end else begin
      for (int c = 1; c <= dly; c++) begin
        @(negedge clk);
        chk("bus_req", bus_req, 1);
        chk("stall_bus", stall_o, 1);
        chk("out_valid_in_bus", out_valid, 0);
        chk("bus_addr", bus_addr, al);
        chk("bus_we", bus_we, st);
        chk("bus_sel", bus_sel, exp_sel);
        if (st) chk("bus_wdata", bus_wdata, exp_bwd);
        obs_sel = bus_sel; obs_bwd = bus_wdata;
        if (c == dly) begin
          bus_ack = 1'b1;
          llbit_clr = clr_ack;
          for (int k = 0; k < 4; k++) begin
            if (bus_we && bus_sel[3-k]) bus_mem[bus_addr + k] = bus_wdata[31-8*k -: 8];
            bus_rdata[31-8*k -: 8] = bus_rd(bus_addr + k);
          end
        end
        @(posedge clk);
      end
      @(negedge clk);
      bus_ack = 1'b0; llbit_clr = 1'b0; in_valid = 1'b0; bus_rdata = $urandom;
      chk("out_valid_resp", out_valid, 1);
      chk("bus_req_done", bus_req, 0);
      chk("stall_resp", stall_o, 0);
      chk("resp_wd", wd_o, wd);
      chk("resp_no_exc", {exc_adel, exc_ades}, 0);
      obs_w = wdata_o;
      if (ld) begin
        chk("load_wreg", wreg_o, wr);
        chk("load_data", wdata_o, exp_v);
        if (ll) m_link = 1'b1;
      end else begin
        chk("store_wreg", wreg_o, sc ? wr : 1'b0);
        if (sc) begin
          chk("sc_result", wdata_o, 1);
          m_link = 1'b0;
        end
        for (int j = 0; j < sz; j++) ref_mem[a + j] = sd[(sz-1-j)*8 +: 8];
      end
      if (clr_ack) m_link = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid_pulse", out_valid, 0);
    chk("exc_pulse", {exc_adel, exc_ades}, 0);
  endtask

  // ---------------- driver: one instruction on the 64-bit instance ----------------
  task automatic do64(input string tag, input logic [3:0] o, input logic [31:0] a,
                      input logic [63:0] sd, input logic [63:0] rd, input bit exp_bus,
                      input logic [7:0] exp_sel, input bit exp_we, input logic [63:0] exp_bwd,
                      input logic [63:0] exp_out, input bit exp_adel);
    @(negedge clk);
    d_in_valid = 1'b1; d_op = o; d_addr = a; d_st_data = sd; d_wd_i = 5'd9; d_wreg_i = 1'b1;
    #1 chk({tag, "_stall"}, d_stall_o, exp_bus);
    @(posedge clk);
    if (exp_bus) begin
      @(negedge clk);
      chk({tag, "_req"}, d_bus_req, 1);
      chk({tag, "_sel"}, d_bus_sel, exp_sel);
      chk({tag, "_addr"}, d_bus_addr, a & ~32'd7);
      chk({tag, "_we"}, d_bus_we, exp_we);
      if (exp_we) chk({tag, "_wdata"}, d_bus_wdata, exp_bwd);
      d_bus_ack = 1'b1; d_bus_rdata = rd;
      @(posedge clk);
    end
    @(negedge clk);
    d_bus_ack = 1'b0; d_in_valid = 1'b0;
    chk({tag, "_valid"}, d_out_valid, 1);
    if (exp_adel) begin
      chk({tag, "_adel"}, d_exc_adel, 1);
      chk({tag, "_badv"}, d_badvaddr_o, a);
    end else if (!exp_we) begin
      chk({tag, "_out"}, d_wdata_o, exp_out);
    end
    @(posedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  logic [31:0] w, b;
  logic [3:0]  s;

  initial begin
    rst = 1'b1;
    in_valid = 0; op = 0; addr = 0; st_data = 0; wd_i = 0; wreg_i = 0;
    llbit_clr = 0; bus_ack = 0; bus_rdata = 0;
    d_in_valid = 0; d_op = 0; d_addr = 0; d_st_data = 0; d_wd_i = 0; d_wreg_i = 0;
    d_llbit_clr = 0; d_bus_ack = 0; d_bus_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_exc", {exc_adel, exc_ades}, 0);
    chk("rst_sel", bus_sel, 0);
    chk("rst64_out_valid", d_out_valid, 0);
    chk("rst64_bus_req", d_bus_req, 0);

    // LB with a three-cycle ack
    set_word(32'h1000, 32'h11803344);
    do_op(4'd1, 32'h1001, 32'd0, 5'd3, 1'b1, 3, 1'b0, w, s, b);
    chk("lb_sel_const", s, 4'b0100);
    chk("lb_data_const", w, 32'hFFFFFF80);

    // SH, half-word replicated on the bus
    do_op(4'd9, 32'h2002, 32'h0000BEEF, 5'd0, 1'b1, 2, 1'b0, w, s, b);
    chk("sh_sel_const", s, 4'b0011);
    chk("sh_wdata_const", b, 32'hBEEFBEEF);

    // misaligned LW
    do_op(4'd5, 32'h3001, 32'd0, 5'd4, 1'b1, 1, 1'b0, w, s, b);

    // LL / SC pairs
    do_op(4'd12, 32'h4000, 32'd0, 5'd5, 1'b1, 1, 1'b0, w, s, b);
    do_op(4'd13, 32'h4000, 32'hCAFEF00D, 5'd6, 1'b1, 1, 1'b0, w, s, b);
    chk("sc_ok_const", w, 32'd1);
    do_op(4'd13, 32'h4000, 32'h12345678, 5'd6, 1'b1, 1, 1'b0, w, s, b);
    chk("sc_again_const", w, 32'd0);
    do_op(4'd12, 32'h4000, 32'd0, 5'd5, 1'b1, 2, 1'b1, w, s, b);
    do_op(4'd13, 32'h4000, 32'h0BADF00D, 5'd6, 1'b1, 1, 1'b0, w, s, b);
    chk("sc_after_clr_on_ack", w, 32'd0);

    // llbit_clr in an idle cycle also breaks the link
    do_op(4'd12, 32'h4004, 32'd0, 5'd5, 1'b1, 1, 1'b0, w, s, b);
    @(negedge clk); llbit_clr = 1'b1;
    @(negedge clk); llbit_clr = 1'b0; m_link = 1'b0;
    do_op(4'd13, 32'h4004, 32'h55AA55AA, 5'd6, 1'b1, 1, 1'b0, w, s, b);
    chk("sc_after_idle_clr", w, 32'd0);

    // reset while a LW waits in BUS; the late ack must be ignored
    do_op(4'd12, 32'h4100, 32'd0, 5'd5, 1'b1, 1, 1'b0, w, s, b);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd5; addr = 32'h4100; wd_i = 5'd7; wreg_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_bus_req", bus_req, 1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; m_link = 1'b0;
    chk("midrst_bus_req", bus_req, 0);
    chk("midrst_outs", {out_valid, wreg_o, wd_o, exc_adel, exc_ades, bus_we}, 0);
    chk("midrst_wdata", wdata_o, 0);
    chk("midrst_addr", bus_addr, 0);
    chk("midrst_stall", stall_o, 0);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack_ignored", out_valid, 0);
    chk("late_ack_no_req", bus_req, 0);
    do_op(4'd13, 32'h4100, 32'h77777777, 5'd6, 1'b1, 1, 1'b0, w, s, b);
    chk("sc_after_reset", w, 32'd0);

    // randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rsd;
      logic [4:0]  rwd;
      ro  = 4'($urandom_range(0, 15));
      ra  = 32'h5000 + 32'($urandom_range(0, 31));
      rsd = $urandom;
      rwd = 5'($urandom_range(0, 31));
      do_op(ro, ra, rsd, rwd, 1'($urandom_range(0, 1)), $urandom_range(1, 4),
            ($urandom_range(0, 7) == 0), w, s, b);
    end

    // 64-bit datapath
    do64("lwu64", 4'd6, 32'h8004, 64'd0, 64'h0123456789ABCDEF, 1'b1, 8'h0F, 1'b0, 64'd0,
         64'h0000000089ABCDEF, 1'b0);
    do64("lw64", 4'd5, 32'h8004, 64'd0, 64'h0123456789ABCDEF, 1'b1, 8'h0F, 1'b0, 64'd0,
         64'hFFFFFFFF89ABCDEF, 1'b0);
    do64("ld64", 4'd7, 32'h8000, 64'd0, 64'h0123456789ABCDEF, 1'b1, 8'hFF, 1'b0, 64'd0,
         64'h0123456789ABCDEF, 1'b0);
    do64("lb64", 4'd1, 32'h8007, 64'd0, 64'h0123456789ABCDEF, 1'b1, 8'h01, 1'b0, 64'd0,
         64'hFFFFFFFFFFFFFFEF, 1'b0);
    do64("ll64", 4'd12, 32'h8000, 64'd0, 64'h0123456789ABCDEF, 1'b1, 8'hF0, 1'b0, 64'd0,
         64'h0000000001234567, 1'b0);
    do64("sd64", 4'd11, 32'h8008, 64'h1122334455667788, 64'd0, 1'b1, 8'hFF, 1'b1,
         64'h1122334455667788, 64'd0, 1'b0);
    do64("sw64", 4'd10, 32'h800C, 64'h00000000DEADBEEF, 64'd0, 1'b1, 8'h0F, 1'b1,
         64'hDEADBEEFDEADBEEF, 64'd0, 1'b0);
    do64("ldmis64", 4'd7, 32'h8004, 64'd0, 64'd0, 1'b0, 8'h00, 1'b0, 64'd0, 64'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
